// File: rtl/ram_burst_controller.sv
// ram_burst_controller
//   Bridges single-word user reads/writes onto a burst-oriented DDR (MIG)
//   application interface. One line of BURST_LEN beats is held locally so
//   repeated reads within the same line are served without DDR traffic.
//   Writes always go out as a full burst: only the targeted lane of the
//   targeted beat is unmasked. Writes to the held line also update it.
//
// Ports
//   clk, reset                   clock, async active-high reset
//   address, mask                byte address, write byte enables (1 = write)
//   read_trigger, write_trigger  request strobes, taken when controller_ready
//   write_value                  write word
//   controller_ready             IDLE and DDR calibrated
//   read_value, read_value_ready read word and its one-cycle strobe
//   error                        0 ok, 1 both triggers, 2 misaligned, 3 timeout
//   mig_app_*                    MIG command / write / read channels
//   mig_init_calib_complete      DDR ready

// Per-lane slice of a write beat and of the write-through merge.
//   sel        this lane is the one being written
//   wdata      user write word
//   wmask      user byte enables, 1 = write
//   old_word   current content of this lane in the held line
//   beat_data  lane data placed on the MIG write beat
//   beat_mask  lane MIG mask, 1 = byte masked
//   merged     old_word with the enabled bytes replaced
module ram_burst_lane #(
  parameter int DATA_SIZE = 32
) (
  input  logic                   sel,
  input  logic [DATA_SIZE-1:0]   wdata,
  input  logic [DATA_SIZE/8-1:0] wmask,
  input  logic [DATA_SIZE-1:0]   old_word,
  output logic [DATA_SIZE-1:0]   beat_data,
  output logic [DATA_SIZE/8-1:0] beat_mask,
  output logic [DATA_SIZE-1:0]   merged
);
  always_comb begin
    beat_data = sel ? wdata : '0;
    beat_mask = sel ? ~wmask : '1;
    merged    = old_word;
    if (sel) begin
      for (int b = 0; b < DATA_SIZE/8; b++) begin
        if (wmask[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end
  end
endmodule

module ram_burst_controller #(
  parameter int DATA_SIZE    = 32,
  parameter int CHUNK_PART   = 128,
  parameter int BURST_LEN    = 8,
  parameter int ADDRESS_SIZE = 28,
  parameter int TIMEOUT      = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDRESS_SIZE-1:0]   address,
  input  logic [DATA_SIZE/8-1:0]    mask,
  input  logic                      read_trigger,
  input  logic                      write_trigger,
  input  logic [DATA_SIZE-1:0]      write_value,
  output logic                      controller_ready,
  output logic [DATA_SIZE-1:0]      read_value,
  output logic                      read_value_ready,
  output logic [3:0]                error,
  output logic [ADDRESS_SIZE-1:0]   mig_app_addr,
  output logic [2:0]                mig_app_cmd,
  output logic                      mig_app_en,
  input  logic                      mig_app_rdy,
  output logic [CHUNK_PART-1:0]     mig_app_wdf_data,
  output logic [CHUNK_PART/8-1:0]   mig_app_wdf_mask,
  output logic                      mig_app_wdf_wren,
  output logic                      mig_app_wdf_end,
  input  logic                      mig_app_wdf_rdy,
  input  logic [CHUNK_PART-1:0]     mig_app_rd_data,
  input  logic                      mig_app_rd_data_valid,
  input  logic                      mig_init_calib_complete
);
  localparam int WORD_BYTES  = DATA_SIZE/8;
  localparam int CHUNK_BYTES = CHUNK_PART/8;
  localparam int LANES       = CHUNK_PART/DATA_SIZE;
  localparam int LINE_BYTES  = BURST_LEN*CHUNK_BYTES;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LANE_W      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CHUNK_SH    = $clog2(CHUNK_BYTES);
  localparam int WORD_SH     = $clog2(WORD_BYTES);
  localparam int TMO_W       = $clog2(TIMEOUT+1);
  localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BURST_LEN-1);
  localparam logic [ADDRESS_SIZE-1:0] LINE_MASK = ~ADDRESS_SIZE'(LINE_BYTES-1);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_CMD, WR_DATA} state_t;

  state_t state_q, state_d;

  // held line
  logic [BURST_LEN-1:0][LANES-1:0][DATA_SIZE-1:0] line_q;
  logic                                           line_vld_q;
  logic [ADDRESS_SIZE-1:0]                        tag_q;

  // latched request
  logic [ADDRESS_SIZE-1:0] req_line_q;
  logic [BEAT_W-1:0]       req_beat_q;
  logic [LANE_W-1:0]       req_lane_q;
  logic [DATA_SIZE-1:0]    req_data_q;
  logic [WORD_BYTES-1:0]   req_mask_q;

  logic [BEAT_W-1:0]       beat_cnt_q;
  logic [TMO_W-1:0]        tmo_cnt_q;
  logic [DATA_SIZE-1:0]    read_value_q;
  logic                    rvr_q;
  logic [3:0]              error_q;

  // address decomposition
  logic [ADDRESS_SIZE-1:0] in_line;
  logic [BEAT_W-1:0]       in_beat;
  logic [LANE_W-1:0]       in_lane;
  logic                    misaligned, both, accept, hit, timed_out;

  assign in_line    = address & LINE_MASK;
  assign in_beat    = BEAT_W'((address >> CHUNK_SH) & ADDRESS_SIZE'(BURST_LEN-1));
  assign in_lane    = LANE_W'((address >> WORD_SH) & ADDRESS_SIZE'(LANES-1));
  assign misaligned = (address & ADDRESS_SIZE'(WORD_BYTES-1)) != '0;
  assign both       = read_trigger && write_trigger;

  // ready is held low through reset so nothing is accepted until release
  assign controller_ready = (state_q == IDLE) && mig_init_calib_complete && !reset;
  assign accept           = controller_ready && (read_trigger || write_trigger);
  assign hit              = line_vld_q && (tag_q == in_line);
  assign timed_out        = (state_q != IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT));

  // per-lane write beat build and write-through merge
  logic [LANES-1:0][DATA_SIZE-1:0]  lane_data, merged_beat;
  logic [LANES-1:0][WORD_BYTES-1:0] lane_mask;
  logic [LANES-1:0][DATA_SIZE-1:0]  rd_beat;
  logic [DATA_SIZE-1:0]             fill_word;
  logic                             beat_sel;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ram_burst_lane #(.DATA_SIZE(DATA_SIZE)) u_lane (
      .sel       (req_lane_q == LANE_W'(l)),
      .wdata     (req_data_q),
      .wmask     (req_mask_q),
      .old_word  (line_q[req_beat_q][l]),
      .beat_data (lane_data[l]),
      .beat_mask (lane_mask[l]),
      .merged    (merged_beat[l])
    );
  end

  assign rd_beat  = mig_app_rd_data;
  // the last beat is not yet in line_q when the fill completes
  assign fill_word = (req_beat_q == LAST_BEAT) ? rd_beat[req_lane_q]
                                               : line_q[req_beat_q][req_lane_q];
  assign beat_sel = (state_q == WR_DATA) && (beat_cnt_q == req_beat_q);

  assign mig_app_addr     = req_line_q;
  assign mig_app_wdf_data = beat_sel ? lane_data : '0;
  assign mig_app_wdf_mask = (state_q != WR_DATA) ? '0 : (beat_sel ? lane_mask : '1);
  assign read_value       = read_value_q;
  assign read_value_ready = rvr_q;
  assign error            = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    mig_app_en       = 1'b0;
    mig_app_cmd      = 3'd0;
    mig_app_wdf_wren = 1'b0;
    mig_app_wdf_end  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !both && !misaligned) begin
          if (write_trigger)  state_d = WR_CMD;
          else if (!hit)      state_d = RD_CMD;
        end
      end
      RD_CMD: begin
        mig_app_en  = 1'b1;
        mig_app_cmd = 3'd1;
        if (mig_app_rdy) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (mig_app_rd_data_valid && beat_cnt_q == LAST_BEAT) state_d = IDLE;
      end
      WR_CMD: begin
        mig_app_en  = 1'b1;
        mig_app_cmd = 3'd2;
        if (mig_app_rdy) state_d = WR_DATA;
      end
      WR_DATA: begin
        mig_app_wdf_wren = 1'b1;
        mig_app_wdf_end  = (beat_cnt_q == LAST_BEAT);
        if (mig_app_wdf_rdy && beat_cnt_q == LAST_BEAT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // abandon the transfer: nothing may handshake on the timeout cycle
    if (timed_out) begin
      state_d          = IDLE;
      mig_app_en       = 1'b0;
      mig_app_cmd      = 3'd0;
      mig_app_wdf_wren = 1'b0;
      mig_app_wdf_end  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_q       <= '0;
      line_vld_q   <= 1'b0;
      tag_q        <= '0;
      req_line_q   <= '0;
      req_beat_q   <= '0;
      req_lane_q   <= '0;
      req_data_q   <= '0;
      req_mask_q   <= '0;
      beat_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
      read_value_q <= '0;
      rvr_q        <= 1'b0;
      error_q      <= 4'd0;
    end else begin
      rvr_q <= 1'b0;
      if (state_q == IDLE) begin
        beat_cnt_q <= '0;
        tmo_cnt_q  <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      if (accept) begin
        if (both)            error_q <= 4'd1;
        else if (misaligned) error_q <= 4'd2;
        else begin
          error_q    <= 4'd0;
          req_line_q <= in_line;
          req_beat_q <= in_beat;
          req_lane_q <= in_lane;
          req_data_q <= write_value;
          req_mask_q <= mask;
          if (read_trigger && hit) begin
            read_value_q <= line_q[in_beat][in_lane];
            rvr_q        <= 1'b1;
          end
        end
      end

      if (timed_out) begin
        error_q    <= 4'd3;
        line_vld_q <= 1'b0;
      end else begin
        case (state_q)
          RD_DATA: begin
            if (mig_app_rd_data_valid) begin
              line_q[beat_cnt_q] <= mig_app_rd_data;
              beat_cnt_q         <= beat_cnt_q + 1'b1;
              if (beat_cnt_q == LAST_BEAT) begin
                line_vld_q   <= 1'b1;
                tag_q        <= req_line_q;
                read_value_q <= fill_word;
                rvr_q        <= 1'b1;
              end
            end
          end
          WR_DATA: begin
            if (mig_app_wdf_wren && mig_app_wdf_rdy) begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
              // write-through once the burst is fully handed to the MIG
              if (beat_cnt_q == LAST_BEAT && line_vld_q && tag_q == req_line_q)
                line_q[req_beat_q] <= merged_beat;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
